// File: rtl/tx_rf_frontend_sequencer.sv
// tx_rf_frontend_sequencer
//   Sequences the RF front end around one transmission: LNA off, T/R switch
//   to TX, PA on, then grants the baseband TX start. When the RF TX window
//   closes the front end is restored to RX in reverse order.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   tx_start_req      1-cycle request from tx_control
//   tx_rf_is_ongoing  level, RF TX window (only looked at in ACTIVE)
//   tsf_pulse_1M      1 us tick, watchdog timebase
//   guard_*_top       guard time minus one, per switching step
//   watchdog_top      max ACTIVE time in us, 0 disables the watchdog
//   lna_en, tr_sw_tx, pa_en   front-end control levels
//   tx_grant, seq_done, req_dropped, watchdog_fired   1-cycle pulses
//   seq_busy, seq_state        status / debug
//
// Configuration
//   TX_WATCHDOG_EN  when defined, a microsecond watchdog can abort ACTIVE.
//                   When undefined, ACTIVE ends only on the RF window
//                   closing and watchdog_fired stays low.
module tx_rf_frontend_sequencer #(
  parameter int GUARD_W = 8,
  parameter int WDOG_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_start_req,
  input  logic               tx_rf_is_ongoing,
  input  logic               tsf_pulse_1M,
  input  logic [GUARD_W-1:0] guard_lna_top,
  input  logic [GUARD_W-1:0] guard_sw_top,
  input  logic [GUARD_W-1:0] guard_pa_top,
  input  logic [WDOG_W-1:0]  watchdog_top,
  output logic               lna_en,
  output logic               tr_sw_tx,
  output logic               pa_en,
  output logic               tx_grant,
  output logic               seq_done,
  output logic               req_dropped,
  output logic               watchdog_fired,
  output logic               seq_busy,
  output logic [2:0]         seq_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LNA_OFF = 3'd1,
    S_SW_TX   = 3'd2,
    S_PA_ON   = 3'd3,
    S_ACTIVE  = 3'd4,
    S_PA_OFF  = 3'd5,
    S_SW_RX   = 3'd6,
    S_LNA_ON  = 3'd7
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [GUARD_W-1:0] guard_cnt;
  logic [GUARD_W-1:0] guard_top_q;
  logic [GUARD_W-1:0] entry_top;
  logic               guard_done;
  logic               state_change;
  logic               rf_seen;
  logic               rf_exit;
  logic               wd_hit;

  // The guard top is captured at state entry, so a state ends when the
  // counter reaches that captured value; live top changes wait for the
  // next entry.
  assign guard_done = (guard_cnt == guard_top_q);
  assign rf_exit    = rf_seen && !tx_rf_is_ongoing;
  assign seq_state  = state;

`ifdef TX_WATCHDOG_EN
  logic [WDOG_W-1:0] wd_cnt;

  // Microsecond counter restarted on each ACTIVE entry; saturates so a
  // long ACTIVE cannot wrap back onto a small limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state_change && next_state == S_ACTIVE) begin
      wd_cnt <= '0;
    end else if (state == S_ACTIVE && tsf_pulse_1M && wd_cnt != '1) begin
      wd_cnt <= wd_cnt + WDOG_W'(1);
    end
  end

  assign wd_hit = (state == S_ACTIVE) && (watchdog_top != '0) &&
                  (wd_cnt == watchdog_top);
`else
  logic unused_wdog_inputs;
  assign unused_wdog_inputs = ^{tsf_pulse_1M, watchdog_top};
  assign wd_hit = 1'b0;
`endif

  // Next-state decode and the guard top to capture for the state entered.
  always_comb begin
    next_state = state;
    entry_top  = '0;
    case (state)
      S_IDLE:    if (tx_start_req)       next_state = S_LNA_OFF;
      S_LNA_OFF: if (guard_done)         next_state = S_SW_TX;
      S_SW_TX:   if (guard_done)         next_state = S_PA_ON;
      S_PA_ON:   if (guard_done)         next_state = S_ACTIVE;
      S_ACTIVE:  if (rf_exit || wd_hit)  next_state = S_PA_OFF;
      S_PA_OFF:  if (guard_done)         next_state = S_SW_RX;
      S_SW_RX:   if (guard_done)         next_state = S_LNA_ON;
      S_LNA_ON:  if (guard_done)         next_state = S_IDLE;
      default:                           next_state = S_IDLE;
    endcase
    state_change = (next_state != state);
    case (next_state)
      S_LNA_OFF, S_LNA_ON: entry_top = guard_lna_top;
      S_SW_TX,   S_SW_RX:  entry_top = guard_sw_top;
      S_PA_ON,   S_PA_OFF: entry_top = guard_pa_top;
      default:             entry_top = '0;
    endcase
  end

  // State register plus registered outputs decoded from the state being
  // entered, so every level changes on the entering edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      guard_cnt      <= '0;
      guard_top_q    <= '0;
      rf_seen        <= 1'b0;
      lna_en         <= 1'b1;
      tr_sw_tx       <= 1'b0;
      pa_en          <= 1'b0;
      tx_grant       <= 1'b0;
      seq_done       <= 1'b0;
      req_dropped    <= 1'b0;
      watchdog_fired <= 1'b0;
      seq_busy       <= 1'b0;
    end else begin
      state <= next_state;
      if (state_change) begin
        guard_cnt   <= '0;
        guard_top_q <= entry_top;
      end else if (!guard_done) begin
        guard_cnt <= guard_cnt + GUARD_W'(1);
      end
      if (state_change) begin
        rf_seen <= 1'b0;
      end else if (state == S_ACTIVE && tx_rf_is_ongoing) begin
        rf_seen <= 1'b1;
      end
      lna_en         <= (next_state == S_IDLE) || (next_state == S_LNA_ON);
      tr_sw_tx       <= (next_state >= S_SW_TX) && (next_state <= S_PA_OFF);
      pa_en          <= (next_state == S_PA_ON) || (next_state == S_ACTIVE);
      tx_grant       <= (state == S_PA_ON) && (next_state == S_ACTIVE);
      seq_done       <= (state == S_LNA_ON) && (next_state == S_IDLE);
      req_dropped    <= tx_start_req && (state != S_IDLE);
      // A normal end of the RF window takes precedence over a watchdog hit
      // in the same cycle.
      watchdog_fired <= wd_hit && !rf_exit;
      seq_busy       <= (next_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_tx_rf_frontend_sequencer.sv
// tb_tx_rf_frontend_sequencer
//   Randomised bench for tx_rf_frontend_sequencer. Each transaction derives
//   the cycle of every front-end event from the guard times, RF window and
//   watchdog limit by plain arithmetic and queues it; a negedge monitor pops
//   the queue whenever the DUT shows an event.
//   Honours TX_WATCHDOG_EN the same way as the design.
module tb_tx_rf_frontend_sequencer;

  localparam int GW  = 8;
  localparam int WW  = 16;
  localparam int K   = 7;
  localparam int INF = 1000000000;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_start_req;
  logic          tx_rf_is_ongoing;
  logic          tsf_pulse_1M;
  logic [GW-1:0] guard_lna_top;
  logic [GW-1:0] guard_sw_top;
  logic [GW-1:0] guard_pa_top;
  logic [WW-1:0] watchdog_top;
  logic          lna_en;
  logic          tr_sw_tx;
  logic          pa_en;
  logic          tx_grant;
  logic          seq_done;
  logic          req_dropped;
  logic          watchdog_fired;
  logic          seq_busy;
  logic [2:0]    seq_state;

  tx_rf_frontend_sequencer #(.GUARD_W(GW), .WDOG_W(WW)) dut (
    .clk(clk), .rst(rst),
    .tx_start_req(tx_start_req), .tx_rf_is_ongoing(tx_rf_is_ongoing),
    .tsf_pulse_1M(tsf_pulse_1M),
    .guard_lna_top(guard_lna_top), .guard_sw_top(guard_sw_top),
    .guard_pa_top(guard_pa_top), .watchdog_top(watchdog_top),
    .lna_en(lna_en), .tr_sw_tx(tr_sw_tx), .pa_en(pa_en),
    .tx_grant(tx_grant), .seq_done(seq_done), .req_dropped(req_dropped),
    .watchdog_fired(watchdog_fired), .seq_busy(seq_busy),
    .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Event kinds: 0 lna_fall 1 sw_rise 2 pa_rise 3 grant 4 pa_fall
  // 5 sw_fall 6 lna_rise 7 done 8 dropped 9 watchdog
  typedef struct {
    int cy;
    int kind;
    int st;
  } ev_t;
  ev_t exp_q[$];

  // Timeline of the transaction in flight (state entry cycles)
  int lf_c, sr_c, pr_c, g_c, e_c, sf_c, lr_c, dn_c, rst_c;

  function automatic string kind_name(input int k);
    case (k)
      0: return "lna_fall";
      1: return "sw_rise";
      2: return "pa_rise";
      3: return "tx_grant";
      4: return "pa_fall";
      5: return "sw_fall";
      6: return "lna_rise";
      7: return "seq_done";
      8: return "req_dropped";
      9: return "watchdog_fired";
      default: return "unknown";
    endcase
  endfunction

  function automatic int state_at(input int y);
    if (rst_c >= 0 && y > rst_c) return 0;
    if (y < lf_c) return 0;
    if (y < sr_c) return 1;
    if (y < pr_c) return 2;
    if (y < g_c)  return 3;
    if (y < e_c)  return 4;
    if (y < sf_c) return 5;
    if (y < lr_c) return 6;
    if (y < dn_c) return 7;
    return 0;
  endfunction

  function automatic void push_exp(input int cy, input int k, input int st);
    ev_t e;
    int  i;
    e.cy = cy; e.kind = k; e.st = st;
    i = exp_q.size();
    while (i > 0 && (exp_q[i-1].cy > cy ||
                     (exp_q[i-1].cy == cy && exp_q[i-1].kind > k)))
      i--;
    exp_q.insert(i, e);
  endfunction

  function automatic void expect_ev(input int cy, input int k, input int st);
    if (rst_c >= 0 && cy > rst_c) return;
    push_exp(cy, k, st);
  endfunction

  function automatic void check_event(input int k);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_%s: seen at cycle %0d, required none",
               kind_name(k), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cy != cyc || e.kind != k || seq_state !== 3'(e.st) ||
          seq_busy !== (e.st != 0)) begin
        bad++;
        $display("[TB] FAIL ev_%s: got %s at cycle %0d state %0d busy %0b, required %s at cycle %0d state %0d",
                 kind_name(e.kind), kind_name(k), cyc, seq_state, seq_busy,
                 kind_name(e.kind), e.cy, e.st);
      end
    end
  endfunction

  task automatic check_output(input string name, input logic [15:0] act,
                              input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: detect events on the falling edge and match them in kind order
  logic prev_lna, prev_sw, prev_pa;
  always @(negedge clk) begin
    bit [9:0] obs;
    if (mon_en) begin
      obs[0] = (prev_lna === 1'b1) && (lna_en === 1'b0);
      obs[1] = (prev_sw  === 1'b0) && (tr_sw_tx === 1'b1);
      obs[2] = (prev_pa  === 1'b0) && (pa_en === 1'b1);
      obs[3] = (tx_grant === 1'b1);
      obs[4] = (prev_pa  === 1'b1) && (pa_en === 1'b0);
      obs[5] = (prev_sw  === 1'b1) && (tr_sw_tx === 1'b0);
      obs[6] = (prev_lna === 1'b0) && (lna_en === 1'b1);
      obs[7] = (seq_done === 1'b1);
      obs[8] = (req_dropped === 1'b1);
      obs[9] = (watchdog_fired === 1'b1);
      while (exp_q.size() > 0 && exp_q[0].cy < cyc) begin
        total++;
        bad++;
        $display("[TB] FAIL missing_%s: required at cycle %0d, absent at cycle %0d",
                 kind_name(exp_q[0].kind), exp_q[0].cy, cyc);
        void'(exp_q.pop_front());
      end
      for (int k = 0; k < 10; k++)
        if (obs[k]) check_event(k);
    end
    prev_lna = lna_en;
    prev_sw  = tr_sw_tx;
    prev_pa  = pa_en;
  end

  task automatic drive_junk_tops();
    guard_lna_top = GW'($urandom);
    guard_sw_top  = GW'($urandom);
    guard_pa_top  = GW'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tx_start_req     = 1'b0;
      tx_rf_is_ongoing = 1'b0;
      rst              = 1'b0;
      tsf_pulse_1M     = (cyc % K == 0);
      drive_junk_tops();
      @(posedge clk); #1;
    end
  endtask

  // One transaction. mode: 0 none, 1 reset in PA_ON, 2 reset deep in ACTIVE,
  // 3 reset at a random busy cycle. A transaction that can never leave
  // ACTIVE is always ended with mode 2.
  task automatic apply_stimulus(input int L, input int S, input int P,
                                input int d, input int w, input int wtop,
                                input int drop_rel, input int ndrop,
                                input int mode, input bit align);
    int c, r0, ne, wdx, e, end_c, limit, nd, m, s, x;
    int drops[4];
    bit fired, is_drop, dup;
    c    = cyc;
    lf_c = c + 1;
    sr_c = lf_c + L + 1;
    pr_c = sr_c + S + 1;
    g_c  = pr_c + P + 1;
    r0   = g_c + d;
    wdx  = INF;
`ifdef TX_WATCHDOG_EN
    if (wtop != 0) begin
      int x1;
      x1  = ((g_c + K - 1) / K) * K;
      wdx = x1 + (wtop - 1) * K + 2;
    end
    if (align && wtop != 0) begin
      r0 = g_c;
      w  = wdx - 1 - r0;
    end
`endif
    ne    = (w > 0) ? r0 + w + 1 : INF;
    fired = (wdx < ne);
    e     = fired ? wdx : ne;
    e_c   = e;
    sf_c  = e + P + 1;
    lr_c  = sf_c + S + 1;
    dn_c  = lr_c + L + 1;
    rst_c = -1;
    m     = mode;
    if (e >= INF && m == 0) m = 2;
    case (m)
      1: rst_c = pr_c + P / 2;
      2: rst_c = g_c + 150;
      3: rst_c = int'($urandom_range(dn_c - 1, c + 1));
      default: rst_c = -1;
    endcase
    end_c = (rst_c >= 0) ? rst_c + 1 : dn_c;
    limit = (rst_c >= 0) ? rst_c : dn_c;
    nd = 0;
    if (drop_rel >= 0 && g_c + drop_rel < limit) begin
      drops[nd] = g_c + drop_rel;
      nd++;
    end
    for (int i = 0; i < ndrop; i++) begin
      if (limit - 1 >= c + 1) begin
        x   = int'($urandom_range(limit - 1, c + 1));
        dup = 1'b0;
        for (int j = 0; j < nd; j++) if (drops[j] == x) dup = 1'b1;
        if (!dup) begin
          drops[nd] = x;
          nd++;
        end
      end
    end

    expect_ev(lf_c, 0, 1);
    expect_ev(sr_c, 1, 2);
    expect_ev(pr_c, 2, 3);
    expect_ev(g_c,  3, 4);
    if (e < INF) expect_ev(e, 4, 5);
    if (fired)   expect_ev(e, 9, 5);
    if (e < INF) begin
      expect_ev(sf_c, 5, 6);
      expect_ev(lr_c, 6, 7);
      expect_ev(dn_c, 7, 0);
    end
    for (int i = 0; i < nd; i++) expect_ev(drops[i] + 1, 8, state_at(drops[i] + 1));
    if (rst_c >= 0) begin
      s = state_at(rst_c);
      if (s >= 1 && s <= 6) push_exp(rst_c + 1, 6, 0);
      if (s >= 2 && s <= 5) push_exp(rst_c + 1, 5, 0);
      if (s == 3 || s == 4) push_exp(rst_c + 1, 4, 0);
    end

    for (int y = c; y < end_c; y++) begin
      is_drop = 1'b0;
      for (int i = 0; i < nd; i++) if (drops[i] == y) is_drop = 1'b1;
      tx_start_req     = (y == c) || is_drop;
      tx_rf_is_ongoing = (w > 0) && (y >= r0) && (y < r0 + w);
      rst              = (y == rst_c);
      watchdog_top     = WW'(wtop);
      tsf_pulse_1M     = (y % K == 0);
      if (y + 1 == lf_c || y + 1 == sr_c || y + 1 == pr_c ||
          y + 1 == e_c  || y + 1 == sf_c || y + 1 == lr_c) begin
        guard_lna_top = GW'(L);
        guard_sw_top  = GW'(S);
        guard_pa_top  = GW'(P);
      end else begin
        drive_junk_tops();
      end
      if (m == 2 && y == rst_c) begin
        @(negedge clk);
        check_output("stuck_active_state", 16'(seq_state), 16'd4);
        check_output("stuck_active_busy", 16'(seq_busy), 16'd1);
      end
      @(posedge clk); #1;
    end
    rst          = 1'b0;
    tx_start_req = 1'b0;
  endtask

  initial begin
    int L, S, P, wt;
    rst = 1'b1; tx_start_req = 1'b0; tx_rf_is_ongoing = 1'b0;
    tsf_pulse_1M = 1'b0; watchdog_top = '0;
    drive_junk_tops();
    rst_c = -1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("reset_lna_en", 16'(lna_en), 16'd1);
    check_output("reset_tr_sw_tx", 16'(tr_sw_tx), 16'd0);
    check_output("reset_pa_en", 16'(pa_en), 16'd0);
    check_output("reset_seq_state", 16'(seq_state), 16'd0);
    check_output("reset_seq_busy", 16'(seq_busy), 16'd0);
    check_output("reset_pulses", 16'({tx_grant, seq_done, req_dropped, watchdog_fired}), 16'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(2, 3, 4, 0, 50, 0, -1, 0, 0, 1'b0);
    apply_stimulus(0, 0, 0, 3, 10, 0, 5, 1, 0, 1'b0);
    idle_cycles(2);
    apply_stimulus(1, 1, 6, 0, 5, 0, -1, 0, 1, 1'b0);
    apply_stimulus(255, 255, 255, 2, 4, 0, -1, 0, 0, 1'b0);
    idle_cycles(1);
    apply_stimulus(1, 2, 1, 0, 0, 0, -1, 1, 0, 1'b0);
    apply_stimulus(1, 1, 1, 0, 0, 3, -1, 0, 0, 1'b0);
    idle_cycles(1);
    apply_stimulus(1, 0, 2, 0, 0, 2, -1, 0, 0, 1'b1);

    for (int t = 0; t < 30; t++) begin
      L = int'($urandom_range(5, 0));
      S = int'($urandom_range(5, 0));
      P = int'($urandom_range(5, 0));
`ifdef TX_WATCHDOG_EN
      wt = int'($urandom_range(4, 0));
`else
      wt = int'($urandom_range(65535, 0));
`endif
      apply_stimulus(L, S, P, int'($urandom_range(4, 0)),
                     int'($urandom_range(20, 1)), wt, -1,
                     int'($urandom_range(2, 0)),
                     ($urandom_range(5, 0) == 0) ? 3 : 0, 1'b0);
      idle_cycles(int'($urandom_range(3, 0)));
    end

    idle_cycles(5);
    check_output("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
